vbs_best_mv_select: RTL and testbench
=====================================

Name: vbs_best_mv_select

Overview:
- Consumes the 41 variable-block-size SADs produced each cycle by the SAD tree (4x4 through 16x16) while the search engine sweeps a motion search window.
- Tracks, per partition, the minimum SAD and the motion vector (mvx, mvy) where it occurred.
- Presents the winning SAD/MV set to mode decision when the sweep completes.

Parameters:
- SAD_WIDTH, 16: width of each unsigned SAD input/output.
- SR, 16: search range; mvx and mvy each span -SR..SR-1.
- MV_WIDTH, 6: signed two's-complement MV component width; must satisfy 2^(MV_WIDTH-1) >= SR.
- NUM_PART, 41: number of partitions per macroblock. Fixed; no other value supported.
- ZERO_BIAS, 32: SAD credit applied at MV (0,0); used only with VBS_ZERO_MV_BIAS_EN.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a new search; one-cycle pulse.
- sad_valid  input  1  sad_in holds the SADs for the current search position.
- sad_in  input  NUM_PART*SAD_WIDTH  packed SADs; partition p occupies bits [p*SAD_WIDTH +: SAD_WIDTH].
- busy  output  1  high while in SEARCH.
- done  output  1  one-cycle pulse when results are final.
- cur_mvx  output  MV_WIDTH  signed MV x of the next position to be accepted.
- cur_mvy  output  MV_WIDTH  signed MV y of the next position to be accepted.
- best_sad  output  NUM_PART*SAD_WIDTH  minimum SAD per partition, same packing as sad_in.
- best_mvx  output  NUM_PART*MV_WIDTH  signed mvx of each minimum.
- best_mvy  output  NUM_PART*MV_WIDTH  signed mvy of each minimum.

Behaviour:
- Partition index map:
  - 0-15: 4x4, row-major (4x4_rc, index = 4r+c).
  - 16-23: 4x8, as 4x8_00..03 then 4x8_10..13.
  - 24-31: 8x4, as 8x4_00, 10, 20, 30, 01, 11, 21, 31.
  - 32-35: 8x8, as 00, 10, 01, 11.
  - 36-37: 16x8_0, 16x8_1.
  - 38-39: 8x16_0, 8x16_1.
  - 40: 16x16.
- Reset values:
  - State IDLE.
  - busy=0, done=0.
  - cur_mvx = cur_mvy = -SR.
  - best_sad all ones; best_mvx = best_mvy = 0.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: sad_valid is ignored. start -> SEARCH; counters load (-SR,-SR) and a first-sample flag is set.
  - SEARCH: each cycle with sad_valid=1 accepts one position at (cur_mvx, cur_mvy). Raster order: mvx increments; at SR-1 it wraps to -SR and mvy increments.
  - Accepting position (SR-1,SR-1) moves to DONE; counters wrap to (-SR,-SR).
  - DONE: lasts one cycle with done=1, then goes to IDLE.
- Total accepted positions: (2*SR)^2, i.e. 1024 at the default SR. sad_valid may be deasserted at any time (stall); counters hold while it is low.
- Per-partition update:
  - On the first accepted sample, load sad_in and the current MV unconditionally.
  - Afterwards, replace only when sad_in[p] < best_sad[p] (strict, unsigned). Ties keep the earliest position in raster order.
- Update timing: best_* are registered and update on the accepting edge. They are valid and stable from the cycle done=1 until the next start.
- start while in SEARCH or DONE: restart immediately, same as from IDLE. The partial search is discarded and done is not pulsed for it.
- start and sad_valid in the same cycle: start wins; that sample is not accepted.
- Asynchronous rst mid-search: all state returns to reset values at once; no done pulse.

Optional Feature:
- Macro: VBS_ZERO_MV_BIAS_EN.
- Defined: at MV (0,0), the compared and stored value is max(sad_in[p] - ZERO_BIAS, 0), saturating at 0.
- Undefined: raw sad_in is used at every position. The ZERO_BIAS parameter is ignored.

Test Plan:
- Reset then idle: sad_valid pulses with no start -> best_sad all ones, MVs 0, busy=0, done never asserts.
- Constant SAD sweep: start, then 1024 valids with every partition = 100 -> done 1 cycle after the 1024th accept; all best_sad=100; all MVs (-16,-16).
- Single minimum: partition 40 = 500 everywhere except 7 at (3,-5); partition 0 = 9 only at (-16,15) -> best 16x16 = 7 @ (3,-5); best 4x4_00 = 9 @ (-16,15).
- Stall and restart: drop sad_valid for 5 cycles mid-sweep -> cur_mv holds. Assert start at accept #300 -> cur_mv returns to (-16,-16); done arrives only after 1024 further accepts.
- Tie-break: partition 36 = 50 at (0,0) and at (1,0), 60 elsewhere -> best_mvx=0, best_mvy=0.
- With VBS_ZERO_MV_BIAS_EN: partition 38 = 40 at (0,0), 20 at (2,2), 30 elsewhere -> best_sad=8 @ (0,0). Without the macro -> best_sad=20 @ (2,2).

Source files
------------

// File: rtl/vbs_best_mv_select_if.sv
// rtl/vbs_best_mv_select_if.sv - search-control and best-SAD/MV result bundle for vbs_best_mv_select
interface vbs_best_mv_select_if #(
  parameter int SAD_WIDTH = 16,
  parameter int MV_WIDTH  = 6,
  parameter int NUM_PART  = 41
);
  logic                            start;
  logic                            sad_valid;
  logic [NUM_PART*SAD_WIDTH-1:0]   sad_in;
  logic                            busy;
  logic                            done;
  logic signed [MV_WIDTH-1:0]      cur_mvx;
  logic signed [MV_WIDTH-1:0]      cur_mvy;
  logic [NUM_PART*SAD_WIDTH-1:0]   best_sad;
  logic [NUM_PART*MV_WIDTH-1:0]    best_mvx;
  logic [NUM_PART*MV_WIDTH-1:0]    best_mvy;

  modport master (
    output start, sad_valid, sad_in,
    input  busy, done, cur_mvx, cur_mvy, best_sad, best_mvx, best_mvy
  );

  modport slave (
    input  start, sad_valid, sad_in,
    output busy, done, cur_mvx, cur_mvy, best_sad, best_mvx, best_mvy
  );
endinterface

// File: rtl/vbs_best_mv_select.sv
// rtl/vbs_best_mv_select.sv - per-partition minimum SAD and MV tracker over a raster search sweep
// Optional zero-MV SAD credit enabled by defining VBS_ZERO_MV_BIAS_EN.
module vbs_best_mv_select #(
  parameter int SAD_WIDTH = 16,
  parameter int SR        = 16,
  parameter int MV_WIDTH  = 6,
  parameter int NUM_PART  = 41,
  parameter int ZERO_BIAS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  vbs_best_mv_select_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic signed [MV_WIDTH-1:0] MV_MIN = MV_WIDTH'(-SR);
  localparam logic signed [MV_WIDTH-1:0] MV_MAX = MV_WIDTH'(SR - 1);
  localparam logic signed [MV_WIDTH-1:0] MV_ONE = MV_WIDTH'(1);
`ifdef VBS_ZERO_MV_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif
  // A zero credit makes the saturating subtract an identity, so one datapath serves both builds.
  localparam logic [SAD_WIDTH-1:0] BIAS = BIAS_EN ? SAD_WIDTH'(ZERO_BIAS) : '0;

  state_t                      state_q, state_d;
  logic signed [MV_WIDTH-1:0]  mvx_q, mvy_q;
  logic                        first_q;
  logic                        accept, last_pos, at_zero;
  logic [SAD_WIDTH-1:0]        cand       [NUM_PART];
  logic [SAD_WIDTH-1:0]        best_sad_q [NUM_PART];
  logic signed [MV_WIDTH-1:0]  best_mvx_q [NUM_PART];
  logic signed [MV_WIDTH-1:0]  best_mvy_q [NUM_PART];

  // start outranks a coincident sample, which is dropped.
  assign accept   = (state_q == SEARCH) && bus.sad_valid && !bus.start;
  assign last_pos = (mvx_q == MV_MAX) && (mvy_q == MV_MAX);
  assign at_zero  = (mvx_q == '0) && (mvy_q == '0);

  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE:    state_d = IDLE;
      SEARCH: begin
        bus.busy = 1'b1;
        if (accept && last_pos) state_d = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.start) state_d = SEARCH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mvx_q   <= MV_MIN;
      mvy_q   <= MV_MIN;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.start) begin
        mvx_q   <= MV_MIN;
        mvy_q   <= MV_MIN;
        first_q <= 1'b1;
      end else if (accept) begin
        first_q <= 1'b0;
        if (mvx_q == MV_MAX) begin
          mvx_q <= MV_MIN;
          mvy_q <= (mvy_q == MV_MAX) ? MV_MIN : mvy_q + MV_ONE;
        end else begin
          mvx_q <= mvx_q + MV_ONE;
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PART; p++) begin
      cand[p] = bus.sad_in[p*SAD_WIDTH +: SAD_WIDTH];
      if (at_zero) cand[p] = (cand[p] > BIAS) ? cand[p] - BIAS : '0;
    end
  end

  // Strict less-than keeps the earliest raster position on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PART; p++) begin
        best_sad_q[p] <= '1;
        best_mvx_q[p] <= '0;
        best_mvy_q[p] <= '0;
      end
    end else if (accept) begin
      for (int p = 0; p < NUM_PART; p++) begin
        if (first_q || (cand[p] < best_sad_q[p])) begin
          best_sad_q[p] <= cand[p];
          best_mvx_q[p] <= mvx_q;
          best_mvy_q[p] <= mvy_q;
        end
      end
    end
  end

  assign bus.cur_mvx = mvx_q;
  assign bus.cur_mvy = mvy_q;

  for (genvar g = 0; g < NUM_PART; g++) begin : g_pack
    assign bus.best_sad[g*SAD_WIDTH +: SAD_WIDTH] = best_sad_q[g];
    assign bus.best_mvx[g*MV_WIDTH +: MV_WIDTH]   = best_mvx_q[g];
    assign bus.best_mvy[g*MV_WIDTH +: MV_WIDTH]   = best_mvy_q[g];
  end
endmodule

// File: tb/tb_vbs_best_mv_select.sv
// tb/tb_vbs_best_mv_select.sv - directed sweeps checked against a position-count model of vbs_best_mv_select
module tb_vbs_best_mv_select;
  localparam int SW = 16;
  localparam int MW = 6;
  localparam int NP = 41;
  localparam int SR = 16;
  localparam int ZB = 32;
  localparam int NPOS = (2*SR)*(2*SR);
  localparam int VW = NP*SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vbs_best_mv_select_if #(.SAD_WIDTH(SW), .MV_WIDTH(MW), .NUM_PART(NP)) bus ();

  vbs_best_mv_select #(
    .SAD_WIDTH(SW), .SR(SR), .MV_WIDTH(MW), .NUM_PART(NP), .ZERO_BIAS(ZB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;

  int m_sad [NP];
  int m_mx  [NP];
  int m_my  [NP];
  bit m_busy, m_done;
  int m_count;

  function automatic int pos_x(int k);
    return -SR + (k % (2*SR));
  endfunction

  function automatic int pos_y(int k);
    return -SR + (k / (2*SR));
  endfunction

  function automatic int eff(int raw, int mx, int my);
`ifdef VBS_ZERO_MV_BIAS_EN
    if (mx == 0 && my == 0) return (raw > ZB) ? raw - ZB : 0;
`endif
    return raw;
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0;
    m_done = 1'b0;
    m_count = 0;
    for (int p = 0; p < NP; p++) begin
      m_sad[p] = (1 << SW) - 1;
      m_mx[p] = 0;
      m_my[p] = 0;
    end
  endfunction

  function automatic void model_step(bit st, bit v, logic [VW-1:0] vec);
    int mx, my, val;
    if (st) begin
      m_busy = 1'b1;
      m_done = 1'b0;
      m_count = 0;
    end else if (m_busy && v) begin
      mx = pos_x(m_count);
      my = pos_y(m_count);
      for (int p = 0; p < NP; p++) begin
        val = eff(int'(vec[p*SW +: SW]), mx, my);
        if (m_count == 0 || val < m_sad[p]) begin
          m_sad[p] = val;
          m_mx[p] = mx;
          m_my[p] = my;
        end
      end
      m_count++;
      if (m_count == NPOS) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_count = 0;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end
  endfunction

  function automatic logic [VW-1:0] pk_sad();
    logic [VW-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p*SW +: SW] = SW'(m_sad[p]);
    return v;
  endfunction

  function automatic logic [VW-1:0] pk_mv(bit y);
    logic [VW-1:0] v;
    v = '0;
    for (int p = 0; p < NP; p++) v[p*MW +: MW] = MW'(y ? m_my[p] : m_mx[p]);
    return v;
  endfunction

  // Stimulus patterns, indexed by test number, as a function of the search position.
  function automatic logic [VW-1:0] gen(int test, int mx, int my);
    logic [VW-1:0] v;
    int s;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      case (test)
        0: s = 100;
        1: begin
          if (p == 40)     s = (mx == 3 && my == -5) ? 7 : 500;
          else if (p == 0) s = (mx == -16 && my == 15) ? 9 : 300;
          else             s = 200;
        end
        2: s = (p == 36) ? (((mx == 0 || mx == 1) && my == 0) ? 50 : 60) : 100;
        default: begin
          if (p == 38) s = (mx == 0 && my == 0) ? 40 : ((mx == 2 && my == 2) ? 20 : 30);
          else         s = ((mx + SR)*37 + (my + SR)*11 + p*5) % 997;
        end
      endcase
      v[p*SW +: SW] = SW'(s);
    end
    return v;
  endfunction

  task automatic cmp(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmpv(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dut_sad(int p);
    return int'(bus.best_sad[p*SW +: SW]);
  endfunction

  function automatic int dut_mx(int p);
    return int'($signed(bus.best_mvx[p*MW +: MW]));
  endfunction

  function automatic int dut_my(int p);
    return int'($signed(bus.best_mvy[p*MW +: MW]));
  endfunction

  always @(negedge clk) begin
    cmp("busy", longint'(bus.busy), longint'(m_busy));
    cmp("done", longint'(bus.done), longint'(m_done));
    cmp("cur_mvx", longint'($signed(bus.cur_mvx)), longint'(pos_x(m_count)));
    cmp("cur_mvy", longint'($signed(bus.cur_mvy)), longint'(pos_y(m_count)));
    if (!m_busy) begin
      cmpv("best_sad", bus.best_sad, pk_sad());
      cmpv("best_mvx", VW'(bus.best_mvx), pk_mv(1'b0));
      cmpv("best_mvy", VW'(bus.best_mvy), pk_mv(1'b1));
    end
  end

  task automatic step(input bit st, input bit v, input int test);
    logic [VW-1:0] vec;
    vec = gen(test, pos_x(m_count), pos_y(m_count));
    bus.start = st;
    bus.sad_valid = v;
    bus.sad_in = vec;
    @(posedge clk);
    model_step(st, v, vec);
    #1;
  endtask

  task automatic sweep(input int test, input bit stall, input bit restart);
    int tot, stalls, guard;
    bit restarted;
    tot = 0; stalls = 0; guard = 0; restarted = 1'b0;
    step(1'b1, 1'b0, test);
    cmp("busy_after_start", longint'(bus.busy), 1);
    while (!m_done && guard < 4*NPOS) begin
      guard++;
      if (stall && tot == 100 && stalls < 5) begin
        step(1'b0, 1'b0, test);
        stalls++;
        if (stalls == 5) begin
          cmp("stall_hold_mvx", longint'($signed(bus.cur_mvx)), -12);
          cmp("stall_hold_mvy", longint'($signed(bus.cur_mvy)), -13);
        end
      end else if (restart && tot == 300 && !restarted) begin
        step(1'b1, 1'b1, test);
        restarted = 1'b1;
        cmp("restart_mvx", longint'($signed(bus.cur_mvx)), -16);
        cmp("restart_mvy", longint'($signed(bus.cur_mvy)), -16);
        cmp("restart_done", longint'(bus.done), 0);
      end else begin
        step(1'b0, 1'b1, test);
        tot++;
      end
    end
    if (!m_done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL sweep_timeout: test %0d got no completion, expected done within %0d cycles", test, 4*NPOS);
    end else begin
      cmp("done_after_last_accept", longint'(bus.done), 1);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    cmp("reset_sad40", dut_sad(40), 65535);
    cmp("reset_mvx0", dut_mx(0), 0);
    cmp("reset_cur_mvx", longint'($signed(bus.cur_mvx)), -16);
    repeat (4) step(1'b0, 1'b1, 0);
    cmp("idle_sad0", dut_sad(0), 65535);
    cmp("idle_busy", longint'(bus.busy), 0);

    sweep(0, 1'b0, 1'b0);
    cmp("const_sad40", dut_sad(40), 100);
    cmp("const_mvx40", dut_mx(40), -16);
    cmp("const_mvy40", dut_my(40), -16);
    cmp("const_sad17", dut_sad(17), 100);

    sweep(1, 1'b0, 1'b0);
    cmp("min_sad40", dut_sad(40), 7);
    cmp("min_mvx40", dut_mx(40), 3);
    cmp("min_mvy40", dut_my(40), -5);
    cmp("min_sad0", dut_sad(0), 9);
    cmp("min_mvx0", dut_mx(0), -16);
    cmp("min_mvy0", dut_my(0), 15);

    sweep(2, 1'b0, 1'b0);
    cmp("tie_sad36", dut_sad(36), 50);
    cmp("tie_mvx36", dut_mx(36), 0);
    cmp("tie_mvy36", dut_my(36), 0);

    sweep(3, 1'b1, 1'b1);
`ifdef VBS_ZERO_MV_BIAS_EN
    cmp("bias_sad38", dut_sad(38), 8);
    cmp("bias_mvx38", dut_mx(38), 0);
    cmp("bias_mvy38", dut_my(38), 0);
`else
    cmp("nobias_sad38", dut_sad(38), 20);
    cmp("nobias_mvx38", dut_mx(38), 2);
    cmp("nobias_mvy38", dut_my(38), 2);
`endif

    step(1'b1, 1'b0, 3);
    repeat (50) step(1'b0, 1'b1, 3);
    rst = 1'b1;
    model_reset();
    #1;
    cmp("arst_busy", longint'(bus.busy), 0);
    cmp("arst_sad38", dut_sad(38), 65535);
    cmp("arst_cur_mvy", longint'($signed(bus.cur_mvy)), -16);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step(1'b0, 1'b1, 3);
    cmp("arst_no_done", longint'(bus.done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
